// File: rtl/axi_read_burst_packer.sv
// AXI read burst packer: reserves R buffer space before forwarding AR and releases whole bursts upstream.
// Optional stall counter output perf_stall_o enabled by defining AXI_READ_PACKER_PERF_EN.
module axi_read_burst_packer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned BUF_DEPTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // upstream AR
    input  logic [ID_WIDTH-1:0]   slv_ar_id,
    input  logic [ADDR_WIDTH-1:0] slv_ar_addr,
    input  logic [7:0]            slv_ar_len,
    input  logic [2:0]            slv_ar_size,
    input  logic [1:0]            slv_ar_burst,
    input  logic                  slv_ar_lock,
    input  logic [3:0]            slv_ar_cache,
    input  logic [2:0]            slv_ar_prot,
    input  logic [3:0]            slv_ar_qos,
    input  logic [3:0]            slv_ar_region,
    input  logic [USER_WIDTH-1:0] slv_ar_user,
    input  logic                  slv_ar_valid,
    output logic                  slv_ar_ready,
    // upstream R
    output logic [ID_WIDTH-1:0]   slv_r_id,
    output logic [DATA_WIDTH-1:0] slv_r_data,
    output logic [1:0]            slv_r_resp,
    output logic                  slv_r_last,
    output logic [USER_WIDTH-1:0] slv_r_user,
    output logic                  slv_r_valid,
    input  logic                  slv_r_ready,
    // downstream AR
    output logic [ID_WIDTH-1:0]   mst_ar_id,
    output logic [ADDR_WIDTH-1:0] mst_ar_addr,
    output logic [7:0]            mst_ar_len,
    output logic [2:0]            mst_ar_size,
    output logic [1:0]            mst_ar_burst,
    output logic                  mst_ar_lock,
    output logic [3:0]            mst_ar_cache,
    output logic [2:0]            mst_ar_prot,
    output logic [3:0]            mst_ar_qos,
    output logic [3:0]            mst_ar_region,
    output logic [USER_WIDTH-1:0] mst_ar_user,
    output logic                  mst_ar_valid,
    input  logic                  mst_ar_ready,
    // downstream R
    input  logic [ID_WIDTH-1:0]   mst_r_id,
    input  logic [DATA_WIDTH-1:0] mst_r_data,
    input  logic [1:0]            mst_r_resp,
    input  logic                  mst_r_last,
    input  logic [USER_WIDTH-1:0] mst_r_user,
    input  logic                  mst_r_valid,
    output logic                  mst_r_ready
`ifdef AXI_READ_PACKER_PERF_EN
    ,
    output logic [31:0]           perf_stall_o
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 10;
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned NW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned EW = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

    localparam logic signed [CW-1:0] DEPTH_S = CW'(BUF_DEPTH);
    localparam logic signed [CW-1:0] ONE_S   = CW'(1);
    localparam logic [NW-1:0]        FULL_N  = NW'(BUF_DEPTH);
    localparam logic [PW-1:0]        LAST_P  = PW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        DRAIN = 2'b01
    } state_t;

    state_t               state_q;
    logic signed [CW-1:0] cred_q, cred_d;
    logic [CW-1:0]        need_u;
    logic signed [CW-1:0] need;
    logic                 ar_fits, ar_hs;

    logic [EW-1:0]        mem [BUF_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]        count_q, count_d;
    logic [NW-1:0]        compl_q, compl_d;
    logic                 full, full_d, empty;
    logic                 push, pop, push_last, pop_last;

    // AR payload is a pure combinational pass-through
    assign mst_ar_id     = slv_ar_id;
    assign mst_ar_addr   = slv_ar_addr;
    assign mst_ar_len    = slv_ar_len;
    assign mst_ar_size   = slv_ar_size;
    assign mst_ar_burst  = slv_ar_burst;
    assign mst_ar_lock   = slv_ar_lock;
    assign mst_ar_cache  = slv_ar_cache;
    assign mst_ar_prot   = slv_ar_prot;
    assign mst_ar_qos    = slv_ar_qos;
    assign mst_ar_region = slv_ar_region;
    assign mst_ar_user   = slv_ar_user;

    assign need_u = {{(CW-8){1'b0}}, slv_ar_len} + CW'(1);
    assign need   = signed'(need_u);

    // Oversize bursts go only into an idle buffer and drive credit negative
    assign ar_fits      = (need <= cred_q) | ((need > DEPTH_S) & (cred_q == DEPTH_S));
    assign mst_ar_valid = slv_ar_valid & ar_fits;
    assign slv_ar_ready = mst_ar_valid & mst_ar_ready;
    assign ar_hs        = slv_ar_ready;

    assign full        = (count_q == FULL_N);
    assign empty       = (count_q == '0);
    assign mst_r_ready = ~full;
    assign slv_r_valid = (state_q == DRAIN) & ~empty;

    assign {slv_r_id, slv_r_data, slv_r_resp, slv_r_last, slv_r_user} = mem[rd_ptr_q];

    assign push      = mst_r_valid & mst_r_ready;
    assign pop       = slv_r_valid & slv_r_ready;
    assign push_last = push & mst_r_last;
    assign pop_last  = pop & slv_r_last;

    always_comb begin
        cred_d = cred_q;
        if (ar_hs) cred_d = cred_d - need;
        if (pop)   cred_d = cred_d + ONE_S;
    end

    always_comb begin
        count_d = count_q;
        if (push & ~pop)      count_d = count_q + NW'(1);
        else if (pop & ~push) count_d = count_q - NW'(1);
        compl_d = compl_q;
        if (push_last & ~pop_last)      compl_d = compl_q + NW'(1);
        else if (pop_last & ~push_last) compl_d = compl_q - NW'(1);
    end

    assign full_d = (count_d == FULL_N);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= {mst_r_id, mst_r_data, mst_r_resp, mst_r_last, mst_r_user};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cred_q   <= DEPTH_S;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            compl_q  <= '0;
        end else begin
            cred_q  <= cred_d;
            count_q <= count_d;
            compl_q <= compl_d;
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    // Release decisions look at next-cycle occupancy so a completed burst shows one cycle after its last push
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HOLD;
        end else begin
            case (state_q)
                HOLD:    if ((count_d != '0) && ((compl_d != '0) || full_d)) state_q <= DRAIN;
                DRAIN:   if (pop_last && (compl_d == '0)) state_q <= HOLD;
                default: state_q <= HOLD;
            endcase
        end
    end

`ifdef AXI_READ_PACKER_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_o <= '0;
        end else if (mst_r_valid && !mst_r_ready && (perf_stall_o != '1)) begin
            perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_read_burst_packer.sv
// Bench for axi_read_burst_packer: AR gating table, R scoreboard, and multi-cycle release/oversize/reset sequences.
module tb_axi_read_burst_packer;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 2;
    localparam int unsigned BD = 8;

    logic          clk_i, rst_i;
    logic [IW-1:0] slv_ar_id;
    logic [AW-1:0] slv_ar_addr;
    logic [7:0]    slv_ar_len;
    logic [2:0]    slv_ar_size;
    logic [1:0]    slv_ar_burst;
    logic          slv_ar_lock;
    logic [3:0]    slv_ar_cache;
    logic [2:0]    slv_ar_prot;
    logic [3:0]    slv_ar_qos;
    logic [3:0]    slv_ar_region;
    logic [UW-1:0] slv_ar_user;
    logic          slv_ar_valid, slv_ar_ready;
    logic [IW-1:0] slv_r_id;
    logic [DW-1:0] slv_r_data;
    logic [1:0]    slv_r_resp;
    logic          slv_r_last;
    logic [UW-1:0] slv_r_user;
    logic          slv_r_valid, slv_r_ready;
    logic [IW-1:0] mst_ar_id;
    logic [AW-1:0] mst_ar_addr;
    logic [7:0]    mst_ar_len;
    logic [2:0]    mst_ar_size;
    logic [1:0]    mst_ar_burst;
    logic          mst_ar_lock;
    logic [3:0]    mst_ar_cache;
    logic [2:0]    mst_ar_prot;
    logic [3:0]    mst_ar_qos;
    logic [3:0]    mst_ar_region;
    logic [UW-1:0] mst_ar_user;
    logic          mst_ar_valid, mst_ar_ready;
    logic [IW-1:0] mst_r_id;
    logic [DW-1:0] mst_r_data;
    logic [1:0]    mst_r_resp;
    logic          mst_r_last;
    logic [UW-1:0] mst_r_user;
    logic          mst_r_valid, mst_r_ready;
`ifdef AXI_READ_PACKER_PERF_EN
    logic [31:0]   perf_stall_o;
`endif

    axi_read_burst_packer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .BUF_DEPTH(BD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len),
        .slv_ar_size(slv_ar_size), .slv_ar_burst(slv_ar_burst), .slv_ar_lock(slv_ar_lock),
        .slv_ar_cache(slv_ar_cache), .slv_ar_prot(slv_ar_prot), .slv_ar_qos(slv_ar_qos),
        .slv_ar_region(slv_ar_region), .slv_ar_user(slv_ar_user),
        .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_id(slv_r_id), .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp),
        .slv_r_last(slv_r_last), .slv_r_user(slv_r_user),
        .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
        .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len),
        .mst_ar_size(mst_ar_size), .mst_ar_burst(mst_ar_burst), .mst_ar_lock(mst_ar_lock),
        .mst_ar_cache(mst_ar_cache), .mst_ar_prot(mst_ar_prot), .mst_ar_qos(mst_ar_qos),
        .mst_ar_region(mst_ar_region), .mst_ar_user(mst_ar_user),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_id(mst_r_id), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp),
        .mst_r_last(mst_r_last), .mst_r_user(mst_r_user),
        .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready)
`ifdef AXI_READ_PACKER_PERF_EN
        , .perf_stall_o(perf_stall_o)
`endif
    );

    typedef logic [IW+DW+2+1+UW-1:0] beat_t;

    typedef struct {
        logic [7:0] len;
        logic       ar_rdy;
        logic       exp_valid;
        logic       exp_slv_ready;
        int         exp_cred;
    } ar_vec_t;

    int    checks = 0;
    int    failures = 0;
    int    stall_cnt = 0;
    int    compl_max = 0;
    beat_t exp_q[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: accepted downstream beats are expected upstream in the same order
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mst_r_valid && mst_r_ready)
                exp_q.push_back({mst_r_id, mst_r_data, mst_r_resp, mst_r_last, mst_r_user});
            if (slv_r_valid && slv_r_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("sb_beat", {slv_r_id, slv_r_data, slv_r_resp, slv_r_last, slv_r_user},
                           exp_q.pop_front());
            end
            if (mst_r_valid && !mst_r_ready) stall_cnt++;
            if (int'(dut.compl_q) > compl_max) compl_max = int'(dut.compl_q);
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        slv_ar_valid = 1'b0; slv_ar_id = '0; slv_ar_addr = '0; slv_ar_len = '0;
        slv_ar_size = 3'd2; slv_ar_burst = 2'd1; slv_ar_lock = 1'b0; slv_ar_cache = 4'h3;
        slv_ar_prot = 3'd0; slv_ar_qos = 4'h0; slv_ar_region = 4'h0; slv_ar_user = '0;
        mst_ar_ready = 1'b0; slv_r_ready = 1'b0;
        mst_r_valid = 1'b0; mst_r_id = '0; mst_r_data = '0; mst_r_resp = '0;
        mst_r_last = 1'b0; mst_r_user = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        stall_cnt = 0;
        compl_max = 0;
    endtask

    task automatic issue_ar(input logic [7:0] len, input logic [IW-1:0] id);
        slv_ar_valid = 1'b1; slv_ar_len = len; slv_ar_id = id;
        slv_ar_addr = AW'($urandom); slv_ar_qos = 4'($urandom); slv_ar_user = UW'($urandom);
        mst_ar_ready = 1'b1;
        #1;
        check("ar_pass_valid", mst_ar_valid, 1);
        check("ar_pass_ready", slv_ar_ready, 1);
        check("ar_copy", {mst_ar_id, mst_ar_addr, mst_ar_len, mst_ar_size, mst_ar_burst, mst_ar_lock,
                          mst_ar_cache, mst_ar_prot, mst_ar_qos, mst_ar_region, mst_ar_user},
                         {id, slv_ar_addr, len, 3'd2, 2'd1, 1'b0, 4'h3, 3'd0, slv_ar_qos, 4'h0, slv_ar_user});
        @(posedge clk_i);
        #1;
        slv_ar_valid = 1'b0;
    endtask

    task automatic push_beat(input logic [IW-1:0] id, input logic last);
        logic ok;
        ok = 1'b0;
        mst_r_valid = 1'b1; mst_r_id = id; mst_r_data = $urandom; mst_r_resp = 2'($urandom);
        mst_r_last = last; mst_r_user = UW'($urandom);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (mst_r_ready) ok = 1'b1;
            @(posedge clk_i);
            #1;
            if (ok) break;
        end
        mst_r_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && !slv_r_valid) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    ar_vec_t  tv[9];
    logic [7:0] issued[$];

    initial begin
        tv[0] = '{8'd3,  1'b0, 1'b1, 1'b0, 8};
        tv[1] = '{8'd7,  1'b0, 1'b1, 1'b0, 8};
        tv[2] = '{8'd8,  1'b0, 1'b1, 1'b0, 8};
        tv[3] = '{8'd3,  1'b1, 1'b1, 1'b1, 4};
        tv[4] = '{8'd1,  1'b1, 1'b1, 1'b1, 2};
        tv[5] = '{8'd2,  1'b1, 1'b0, 1'b0, 2};
        tv[6] = '{8'd15, 1'b1, 1'b0, 1'b0, 2};
        tv[7] = '{8'd1,  1'b1, 1'b1, 1'b1, 0};
        tv[8] = '{8'd0,  1'b1, 1'b0, 1'b0, 0};

        do_reset();
        check("rst_slv_r_valid", slv_r_valid, 0);
        check("rst_mst_r_ready", mst_r_ready, 1);
        check("rst_cred", int'(dut.cred_q), 8);
        check("rst_state", dut.state_q, 0);
        check("rst_compl", dut.compl_q, 0);
        check("rst_slv_ar_ready", slv_ar_ready, 0);

        // AR gating table
        for (int i = 0; i < 9; i++) begin
            slv_ar_valid = 1'b1; slv_ar_len = tv[i].len; slv_ar_id = IW'(i);
            mst_ar_ready = tv[i].ar_rdy;
            #1;
            check("tbl_mst_ar_valid", mst_ar_valid, tv[i].exp_valid);
            check("tbl_slv_ar_ready", slv_ar_ready, tv[i].exp_slv_ready);
            if (tv[i].ar_rdy && tv[i].exp_valid) issued.push_back(tv[i].len);
            tick();
            slv_ar_valid = 1'b0;
            check("tbl_cred", int'(dut.cred_q), tv[i].exp_cred);
        end
        slv_r_ready = 1'b1;
        foreach (issued[k])
            for (int b = 0; b <= int'(issued[k]); b++) push_beat(IW'(k), b == int'(issued[k]));
        wait_drain();
        check("tbl_cred_back", int'(dut.cred_q), 8);

        // Single burst with gaps: held until the last push, then released back-to-back
        do_reset();
        slv_r_ready = 1'b1;
        issue_ar(8'd3, 4'h1);
        check("a_cred_after_ar", int'(dut.cred_q), 4);
        for (int b = 0; b < 3; b++) begin
            push_beat(4'h1, 1'b0);
            check("a_hold_valid", slv_r_valid, 0);
            tick();
        end
        push_beat(4'h1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            check("a_b2b_valid", slv_r_valid, 1);
            tick();
        end
        check("a_done_valid", slv_r_valid, 0);
        check("a_cred_back", int'(dut.cred_q), 8);

        // Credit stall until one upstream pop, then mid-burst reset
        do_reset();
        issue_ar(8'd3, 4'h1);
        issue_ar(8'd1, 4'h2);
        check("b_cred", int'(dut.cred_q), 2);
        slv_ar_valid = 1'b1; slv_ar_len = 8'd2; slv_ar_id = 4'h3; mst_ar_ready = 1'b1;
        #1;
        check("b_block_early", mst_ar_valid, 0);
        for (int b = 0; b < 4; b++) push_beat(4'h1, b == 3);
        check("b_block_buffered", mst_ar_valid, 0);
        check("b_r_valid", slv_r_valid, 1);
        slv_r_ready = 1'b1;
        tick();
        slv_r_ready = 1'b0;
        #1;
        check("b_unblock_valid", mst_ar_valid, 1);
        check("b_unblock_ready", slv_ar_ready, 1);
        tick();
        slv_ar_valid = 1'b0;
        check("b_cred_zero", int'(dut.cred_q), 0);
        rst_i = 1'b1;
        #1;
        check("rstmid_r_valid", slv_r_valid, 0);
        check("rstmid_cred", int'(dut.cred_q), 8);
        check("rstmid_state", dut.state_q, 0);
        check("rstmid_mst_r_ready", mst_r_ready, 1);
        tick();
        rst_i = 1'b0;
        exp_q.delete();

        // AR handshake and upstream pop in the same cycle
        do_reset();
        issue_ar(8'd3, 4'h1);
        issue_ar(8'd1, 4'h2);
        for (int b = 0; b < 4; b++) push_beat(4'h1, b == 3);
        slv_ar_valid = 1'b1; slv_ar_len = 8'd1; slv_ar_id = 4'h3; mst_ar_ready = 1'b1;
        slv_r_ready = 1'b1;
        #1;
        check("c_ar_valid", mst_ar_valid, 1);
        tick();
        slv_ar_valid = 1'b0;
        check("c_cred_one", int'(dut.cred_q), 1);
        for (int b = 0; b < 2; b++) push_beat(4'h2, b == 1);
        for (int b = 0; b < 2; b++) push_beat(4'h3, b == 1);
        wait_drain();
        check("c_cred_back", int'(dut.cred_q), 8);

        // Oversize burst
        do_reset();
        slv_r_ready = 1'b1;
        issue_ar(8'd0, 4'h5);
        slv_ar_valid = 1'b1; slv_ar_len = 8'd15; slv_ar_id = 4'h6; mst_ar_ready = 1'b1;
        #1;
        check("d_block_cred7", mst_ar_valid, 0);
        push_beat(4'h5, 1'b1);
        check("d_block_still", mst_ar_valid, 0);
        tick();
        check("d_cred_full", int'(dut.cred_q), 8);
        check("d_oversize_go", mst_ar_valid, 1);
        tick();
        slv_ar_valid = 1'b0;
        check("d_cred_neg", int'(dut.cred_q), -8);
        slv_r_ready = 1'b0;
        for (int b = 0; b < 8; b++) push_beat(4'h6, 1'b0);
        check("d_full_ready", mst_r_ready, 0);
        check("d_full_drain", slv_r_valid, 1);
        check("d_full_state", dut.state_q, 1);
        slv_ar_valid = 1'b1; slv_ar_len = 8'd0;
        #1;
        check("d_neg_block", mst_ar_valid, 0);
        slv_ar_valid = 1'b0;
        fork
            for (int b = 8; b < 16; b++) push_beat(4'h6, b == 15);
            begin
                for (int s = 0; s < 3; s++) begin
                    check("d_stall_ready", mst_r_ready, 0);
                    tick();
                end
                slv_r_ready = 1'b1;
            end
        join
        wait_drain();
        check("d_cred_back", int'(dut.cred_q), 8);
        check("d_state_hold", dut.state_q, 0);
        check("d_stalls_seen", stall_cnt >= 3, 1);
`ifdef AXI_READ_PACKER_PERF_EN
        check("d_perf_stall", perf_stall_o, stall_cnt);
`endif

        // Back-to-back single-beat bursts
        do_reset();
        slv_r_ready = 1'b1;
        for (int i = 0; i < 5; i++) issue_ar(8'd0, IW'(i + 8));
        check("e_cred", int'(dut.cred_q), 3);
        for (int i = 0; i < 5; i++) begin
            push_beat(IW'(i + 8), 1'b1);
            check("e_release_next", slv_r_valid, 1);
        end
        wait_drain();
        check("e_compl_max", compl_max <= 2, 1);
        check("e_no_stall", stall_cnt, 0);
        check("e_cred_back", int'(dut.cred_q), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
